dct_quantizer_arbiter: RTL and testbench

- Shares the single quantizer between the N_SRC column DCT engines of the jfpjc compressor.
- Each DCT engine finishes a 64-coefficient block into its double-buffered output EBR and raises block_ready.
- This block grants one engine at a time in round-robin order and reads its 64 coefficients via a shared fetch address.
- It streams them to the quantizer with index/tag under valid/ready backpressure, then pulses block_release so the engine can free that buffer.

---
 rtl/jfpjc_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/dct_quantizer_arbiter.sv | 138 +++++++++++++
 tb/tb_dct_quantizer_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jfpjc_pkg.sv
// rtl/jfpjc_pkg.sv - shared constants and types for the jfpjc DCT-to-quantizer path
package jfpjc_pkg;
  localparam int BLOCK_COEFS = 64;
  localparam int COEF_W      = 16;
  localparam int IDX_W       = 6;
  localparam int TAG_W       = 8;
  localparam int SEQ_LSB     = 6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    RELEASE
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin pick starting at a registered pointer
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         advance_i,
  input  logic [W-1:0] last_i,
  input  logic [N-1:0] req_i,
  output logic [W-1:0] pick_o,
  output logic         valid_o
);
  logic [W-1:0] ptr_q;
  logic [W-1:0] base;
  int           idx;

  // A clear in the same cycle as a request already searches from zero.
  assign base = clear_i ? '0 : ptr_q;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        pick_o  = W'(idx);
        valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (last_i == W'(N - 1)) ? '0 : last_i + W'(1);
    end
  end
endmodule

// File: rtl/dct_quantizer_arbiter.sv
// rtl/dct_quantizer_arbiter.sv - shares one quantizer between the column DCT engines
module dct_quantizer_arbiter
  import jfpjc_pkg::*;
#(
  parameter int N_SRC  = 5,
  parameter int COEF_W = jfpjc_pkg::COEF_W,
  parameter int SRC_W  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [N_SRC-1:0]          block_ready,
  output logic [N_SRC-1:0]          block_release,
  output logic [IDX_W-1:0]          fetch_addr,
  output logic                      fetch_en,
  input  logic [N_SRC*COEF_W-1:0]   fetch_data,
  output logic [COEF_W-1:0]         coef_out,
  output logic                      coef_valid,
  input  logic                      coef_ready,
  output logic [TAG_W-1:0]          coef_tag,
  output logic [SRC_W-1:0]          coef_src
);
  arb_state_e       state_q;
  logic [SRC_W-1:0] grant_q;
  logic [IDX_W-1:0] issue_cnt_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [1:0]       seq_q;
  logic [N_SRC-1:0] release_q;
  logic             rd_pend_q;

  logic [COEF_W-1:0] fifo_coef_q [2];
  logic [TAG_W-1:0]  fifo_tag_q  [2];
  logic              fifo_rd_q;
  logic              fifo_wr_q;
  logic [1:0]        fifo_cnt_q;
  logic [1:0]        fifo_cnt_d;

  logic [2:0]        occupancy;
  logic              pop;
  logic              issue;
  logic              arb_valid;
  logic              arb_clear;
  logic              arb_advance;
  logic [SRC_W-1:0]  arb_pick;
  logic [COEF_W-1:0] rd_data;

  assign coef_valid = (fifo_cnt_q != 2'd0);
  assign pop        = coef_valid && coef_ready;

  // Credit counts the entry leaving this cycle, so a 2-deep skid sustains one read per cycle.
  assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue      = (state_q == FETCH) && (occupancy < 3'd2);
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};

  assign rd_data       = fetch_data[grant_q*COEF_W +: COEF_W];
  assign fetch_en      = issue;
  assign fetch_addr    = issue_cnt_q;
  assign coef_out      = fifo_coef_q[fifo_rd_q];
  assign coef_tag      = fifo_tag_q[fifo_rd_q];
  assign coef_src      = grant_q;
  assign block_release = release_q;

  assign arb_clear   = frame_start && (state_q == IDLE);
  assign arb_advance = (state_q == RELEASE);

  rr_arbiter #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_rr (
    .clock_i   (clock),
    .reset_i   (reset),
    .clear_i   (arb_clear),
    .advance_i (arb_advance),
    .last_i    (grant_q),
    .req_i     (block_ready),
    .pick_o    (arb_pick),
    .valid_o   (arb_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      issue_cnt_q    <= '0;
      rd_idx_q       <= '0;
      seq_q          <= '0;
      release_q      <= '0;
      rd_pend_q      <= 1'b0;
      fifo_coef_q[0] <= '0;
      fifo_coef_q[1] <= '0;
      fifo_tag_q[0]  <= '0;
      fifo_tag_q[1]  <= '0;
      fifo_rd_q      <= 1'b0;
      fifo_wr_q      <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      rd_pend_q  <= issue;
      rd_idx_q   <= issue_cnt_q;
      fifo_cnt_q <= fifo_cnt_d;
      release_q  <= '0;
      if (rd_pend_q) begin
        fifo_coef_q[fifo_wr_q] <= rd_data;
        fifo_tag_q[fifo_wr_q]  <= {seq_q, rd_idx_q};
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;

      case (state_q)
        IDLE: begin
          if (frame_start) seq_q <= '0;
          if (arb_valid) begin
            grant_q     <= arb_pick;
            issue_cnt_q <= '0;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + IDX_W'(1);
            if (issue_cnt_q == IDX_W'(BLOCK_COEFS - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the last coefficient is accepted so the release lands on the next cycle.
          if (fifo_cnt_d == 2'd0) begin
            release_q <= N_SRC'(1) << grant_q;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          seq_q   <= seq_q + 2'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dct_quantizer_arbiter.sv
// tb/tb_dct_quantizer_arbiter.sv - randomized self-checking bench against a block-level model
module tb_dct_quantizer_arbiter;
  localparam int N_SRC  = 5;
  localparam int COEF_W = 16;
  localparam int SRC_W  = 3;
  localparam int NB     = 64;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    frame_start;
  logic [N_SRC-1:0]        block_ready;
  logic [N_SRC-1:0]        block_release;
  logic [5:0]              fetch_addr;
  logic                    fetch_en;
  logic [N_SRC*COEF_W-1:0] fetch_data;
  logic [COEF_W-1:0]       coef_out;
  logic                    coef_valid;
  logic                    coef_ready;
  logic [7:0]              coef_tag;
  logic [SRC_W-1:0]        coef_src;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [7:0]        tag;
    logic [COEF_W-1:0] data;
  } beat_t;

  logic [COEF_W-1:0] mem [N_SRC][NB];
  beat_t       exp_q[$];
  int          rel_order[$];
  int          rel_cyc[$];
  int          exp_order[$];
  int          rearm [N_SRC];
  int          m_ptr, m_seq, m_grant;
  bit          m_busy;
  int          cyc, beats_seen, ready_mode, req_cyc;
  bit          prev_stall;
  logic [31:0] prev_out;

  always #5 clock = ~clock;

  dct_quantizer_arbiter #(
    .N_SRC (N_SRC),
    .COEF_W(COEF_W),
    .SRC_W (SRC_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_start   (frame_start),
    .block_ready   (block_ready),
    .block_release (block_release),
    .fetch_addr    (fetch_addr),
    .fetch_en      (fetch_en),
    .fetch_data    (fetch_data),
    .coef_out      (coef_out),
    .coef_valid    (coef_valid),
    .coef_ready    (coef_ready),
    .coef_tag      (coef_tag),
    .coef_src      (coef_src)
  );

  // EBR model: one-cycle read latency, every engine answers the shared address.
  always @(posedge clock) begin
    if (fetch_en) begin
      for (int e = 0; e < N_SRC; e++) fetch_data[e*COEF_W +: COEF_W] <= mem[e][fetch_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int rr_pick(input logic [N_SRC-1:0] pend, input int ptr);
    for (int k = 0; k < N_SRC; k++) begin
      if (pend[(ptr + k) % N_SRC]) return (ptr + k) % N_SRC;
    end
    return -1;
  endfunction

  // Once the arbiter is free, the next block is the first pending engine at or after the pointer.
  task automatic predict();
    beat_t b;
    if (!m_busy && block_ready != '0) begin
      m_grant = rr_pick(block_ready, m_ptr);
      m_busy  = 1'b1;
      for (int i = 0; i < NB; i++) begin
        b.src  = SRC_W'(m_grant);
        b.tag  = {2'(m_seq), 6'(i)};
        b.data = mem[m_grant][i];
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic monitor();
    beat_t       b;
    logic [31:0] now_out;
    now_out = {5'b0, coef_src, coef_tag, coef_out};
    if (prev_stall) begin
      check("hold_valid", 32'(coef_valid), 32'd1);
      check("hold_outputs", now_out, prev_out);
    end
    if (coef_valid && coef_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("coef_src", 32'(coef_src), 32'(b.src));
        check("coef_tag", 32'(coef_tag), 32'(b.tag));
        check("coef_out", 32'(coef_out), 32'(b.data));
        beats_seen++;
      end
    end
    if (block_release != '0) begin
      check("release_when_busy", 32'(m_busy), 32'd1);
      check("release_mask", 32'(block_release), 32'd1 << m_grant);
      check("beats_left_at_release", 32'(exp_q.size()), 32'd0);
      rel_order.push_back(m_grant);
      rel_cyc.push_back(cyc);
      if (rearm[m_grant] > 0) rearm[m_grant]--;
      else block_ready[m_grant] = 1'b0;
      m_ptr  = (m_grant + 1) % N_SRC;
      m_seq  = (m_seq + 1) % 4;
      m_busy = 1'b0;
      predict();
    end
    prev_stall = coef_valid && !coef_ready;
    prev_out   = now_out;
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    case (ready_mode)
      0:       coef_ready = 1'b1;
      1:       coef_ready = ~coef_ready;
      2:       coef_ready = 1'($urandom_range(0, 1));
      default: coef_ready = 1'b0;
    endcase
    @(negedge clock);
    if (!reset) monitor();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_release"}, 32'(block_release), 32'd0);
    check({tag, "_fetch_en"}, 32'(fetch_en), 32'd0);
    check({tag, "_fetch_addr"}, 32'(fetch_addr), 32'd0);
    check({tag, "_valid"}, 32'(coef_valid), 32'd0);
    check({tag, "_coef_out"}, 32'(coef_out), 32'd0);
    check({tag, "_tag"}, 32'(coef_tag), 32'd0);
    check({tag, "_src"}, 32'(coef_src), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_seq      = 0;
    m_busy     = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ready_mode = 3;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || block_ready != '0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", 32'(!m_busy && block_ready == '0), 32'd1);
    tick();
  endtask

  task automatic wait_beats(input int count, input int budget);
    int n;
    n = 0;
    while (beats_seen < count && n < budget) begin
      tick();
      n++;
    end
    check("beats_within_budget", 32'(beats_seen >= count), 32'd1);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, 32'(rel_order.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < rel_order.size(); i++) begin
      check(tag, 32'(rel_order[i]), 32'(exp_order[i]));
    end
    rel_order.delete();
    rel_cyc.delete();
  endtask

  task automatic randomize_mem();
    for (int e = 0; e < N_SRC; e++) begin
      for (int i = 0; i < NB; i++) mem[e][i] = COEF_W'($urandom);
    end
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    block_ready = '0;
    coef_ready  = 1'b0;
    ready_mode  = 3;
    cyc         = 0;
    beats_seen  = 0;
    for (int e = 0; e < N_SRC; e++) rearm[e] = 0;
    randomize_mem();
    do_reset();

    // Single request, engine 2 returns addr*3.
    for (int i = 0; i < NB; i++) mem[2][i] = COEF_W'(i * 3);
    ready_mode  = 0;
    block_ready = 5'b00100;
    req_cyc     = cyc;
    predict();
    wait_idle(200);
    check("single_latency", 32'(rel_cyc.size() > 0 ? rel_cyc[0] - req_cyc : -1), 32'd67);
    exp_order = '{2};
    check_order("single_order");

    // All engines at once from reset: round-robin order and back-to-back spacing.
    do_reset();
    randomize_mem();
    ready_mode  = 0;
    block_ready = 5'b11111;
    predict();
    wait_idle(600);
    for (int i = 1; i < rel_cyc.size(); i++) begin
      check("b2b_gap", 32'(rel_cyc[i] - rel_cyc[i-1] <= 68), 32'd1);
    end
    exp_order = '{0, 1, 2, 3, 4};
    check_order("all5_order");

    // Backpressure: toggling ready, then a 10-cycle stall mid-block.
    randomize_mem();
    ready_mode  = 1;
    beats_seen  = 0;
    block_ready = 5'b10000;
    predict();
    wait_beats(30, 200);
    ready_mode = 3;
    for (int i = 0; i < 10; i++) tick();
    ready_mode = 1;
    wait_idle(400);
    exp_order = '{4};
    check_order("stall_order");

    // Persistent requester 0 against pending engine 3.
    randomize_mem();
    ready_mode  = 2;
    rearm[0]    = 1;
    block_ready = 5'b01001;
    predict();
    wait_idle(1200);
    exp_order = '{0, 3, 0};
    check_order("starve_order");

    // Reset after beat 20 of engine 1: no release, then full re-service.
    randomize_mem();
    ready_mode  = 0;
    beats_seen  = 0;
    block_ready = 5'b00010;
    predict();
    wait_beats(21, 200);
    reset      = 1'b1;
    ready_mode = 3;
    tick();
    check_zero("midreset");
    tick();
    check("midreset_no_release", 32'(block_release), 32'd0);
    check("midreset_req_held", 32'(block_ready), 32'b00010);
    reset = 1'b0;
    model_reset();
    rel_order.delete();
    rel_cyc.delete();
    ready_mode = 0;
    predict();
    wait_idle(200);
    exp_order = '{1};
    check_order("midreset_reserve");

    // Two more blocks move the pointer and sequence off zero, then frame_start in IDLE.
    randomize_mem();
    ready_mode  = 2;
    block_ready = 5'b01100;
    predict();
    wait_idle(800);
    exp_order = '{2, 3};
    check_order("pre_frame_order");
    frame_start = 1'b1;
    m_ptr       = 0;
    m_seq       = 0;
    tick();
    frame_start = 1'b0;
    block_ready = 5'b10001;
    predict();
    wait_idle(800);
    exp_order = '{0, 4};
    check_order("frame_start_order");

    // Random request sets under random backpressure.
    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      ready_mode  = 2;
      block_ready = N_SRC'($urandom_range(1, 31));
      predict();
      wait_idle(3000);
      check("random_release_count", 32'(rel_order.size() >= 1), 32'd1);
      rel_order.delete();
      rel_cyc.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
